// File: rtl/ex_stage_pkg.sv
// Shared types and bundle layouts for the execute stage.
// Field positions of ID_EX / EX_MEM, ALU codes and forwarding helper.
package ex_stage_pkg;

  localparam int ID_EX_W  = 230;
  localparam int EX_MEM_W = 106;

  localparam logic [4:0] NONE_REG = 5'd0;
  localparam logic [4:0] RA_REG   = 5'd31;
  localparam logic [4:0] XP_REG   = 5'd26;

  localparam int ID_RSDATA_LSB = 0;
  localparam int ID_RSDATA_MSB = 31;
  localparam int ID_RTDATA_LSB = 32;
  localparam int ID_RTDATA_MSB = 63;
  localparam int ID_RS_LSB     = 64;
  localparam int ID_RS_MSB     = 68;
  localparam int ID_RT_LSB     = 69;
  localparam int ID_RT_MSB     = 73;
  localparam int ID_RD_LSB     = 74;
  localparam int ID_RD_MSB     = 78;
  localparam int ID_SIGN       = 79;
  localparam int ID_FUN_LSB    = 80;
  localparam int ID_FUN_MSB    = 85;
  localparam int ID_SRC2       = 86;
  localparam int ID_SRC1       = 87;
  localparam int ID_BADDR_LSB  = 88;
  localparam int ID_BADDR_MSB  = 119;
  localparam int ID_MEMWR      = 120;
  localparam int ID_MEMRD      = 121;
  localparam int ID_REGWR      = 122;
  localparam int ID_MTR_LSB    = 123;
  localparam int ID_MTR_MSB    = 124;
  localparam int ID_LUDATA_LSB = 125;
  localparam int ID_LUDATA_MSB = 156;
  localparam int ID_LUOP       = 157;
  localparam int ID_PC4_LSB    = 158;
  localparam int ID_PC4_MSB    = 189;
  localparam int ID_SHAMT_LSB  = 190;
  localparam int ID_SHAMT_MSB  = 194;
  localparam int ID_IMM_LSB    = 195;
  localparam int ID_IMM_MSB    = 226;
  localparam int ID_BRANCH     = 227;
  localparam int ID_RDST_LSB   = 228;
  localparam int ID_RDST_MSB   = 229;

  localparam int EM_ALU_LSB    = 0;
  localparam int EM_ALU_MSB    = 31;
  localparam int EM_STORE_LSB  = 32;
  localparam int EM_STORE_MSB  = 63;
  localparam int EM_WREG_LSB   = 64;
  localparam int EM_WREG_MSB   = 68;
  localparam int EM_MEMWR      = 69;
  localparam int EM_MEMRD      = 70;
  localparam int EM_REGWR      = 71;
  localparam int EM_MTR_LSB    = 72;
  localparam int EM_MTR_MSB    = 73;
  localparam int EM_PC4_LSB    = 74;
  localparam int EM_PC4_MSB    = 105;

  typedef enum logic [1:0] {
    GRP_ARITH = 2'b00,
    GRP_LOGIC = 2'b01,
    GRP_SHIFT = 2'b10,
    GRP_CMP   = 2'b11
  } alu_grp_e;

  typedef enum logic [3:0] {
    LOG_AND = 4'b1000,
    LOG_OR  = 4'b1110,
    LOG_XOR = 4'b0110,
    LOG_NOR = 4'b0001,
    LOG_A   = 4'b1010
  } alu_log_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b11
  } alu_sh_e;

  typedef enum logic [2:0] {
    CMP_NE  = 3'b000,
    CMP_EQ  = 3'b001,
    CMP_LT  = 3'b010,
    CMP_LTZ = 3'b101,
    CMP_LEZ = 3'b110,
    CMP_GTZ = 3'b111
  } alu_cmp_e;

  typedef enum logic [1:0] {
    DST_RD = 2'b00,
    DST_RT = 2'b01,
    DST_RA = 2'b10,
    DST_XP = 2'b11
  } reg_dst_e;

  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC  = 2'b10
  } mem_to_reg_e;

  // The nearer producer (EX_MEM) wins; register 0 is never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  src,
    input logic [31:0] id_data,
    input logic        ex_rw,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_data,
    input logic        wb_rw,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (ex_rw && ex_rd != NONE_REG && ex_rd == src)
      return ex_data;
    if (wb_rw && wb_rd != NONE_REG && wb_rd == src)
      return wb_data;
    return id_data;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU: arithmetic, logic, shift and compare groups.
// Compare results are a single flag in bit 0.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [5:0]  i_fun,
  input  logic        i_sign,
  output logic [31:0] o_z
);

  logic w_lt;
  logic w_a_neg;
  logic w_a_zero;
  logic w_flag;

  assign w_lt     = i_sign ? ($signed(i_a) < $signed(i_b))
                           : (i_a < i_b);
  assign w_a_neg  = i_a[31];
  assign w_a_zero = (i_a == 32'd0);

  always_comb begin
    w_flag = 1'b0;
    case (i_fun[3:1])
      CMP_EQ:  w_flag = (i_a == i_b);
      CMP_NE:  w_flag = (i_a != i_b);
      CMP_LT:  w_flag = w_lt;
      CMP_LEZ: w_flag = w_a_neg | w_a_zero;
      CMP_LTZ: w_flag = w_a_neg;
      CMP_GTZ: w_flag = ~w_a_neg & ~w_a_zero;
      default: w_flag = 1'b0;
    endcase
  end

  always_comb begin
    o_z = '0;
    case (i_fun[5:4])
      GRP_ARITH: o_z = i_fun[0] ? (i_a - i_b) : (i_a + i_b);
      GRP_LOGIC: begin
        case (i_fun[3:0])
          LOG_AND: o_z = i_a & i_b;
          LOG_OR:  o_z = i_a | i_b;
          LOG_XOR: o_z = i_a ^ i_b;
          LOG_NOR: o_z = ~(i_a | i_b);
          LOG_A:   o_z = i_a;
          default: o_z = '0;
        endcase
      end
      GRP_SHIFT: begin
        case (i_fun[1:0])
          SH_SLL:  o_z = i_b << i_a[4:0];
          SH_SRL:  o_z = i_b >> i_a[4:0];
          SH_SRA:  o_z = $signed(i_b) >>> i_a[4:0];
          default: o_z = '0;
        endcase
      end
      GRP_CMP:   o_z = {31'b0, w_flag};
      default:   o_z = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolve, EX_MEM register.
// The branch redirect is combinational from the instruction now in EX.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_EX_W-1:0]  ID_EX,
  input  logic                MEM_WB_RegWrite,
  input  logic [4:0]          MEM_WB_Rd,
  input  logic [31:0]         MEM_WB_RdData,
  input  logic                EX_Flush,
  output logic                branch_taken,
  output logic [31:0]         branch_target,
  output logic [4:0]          EX_MEM_Rd,
  output logic                EX_MEM_RegWrite,
  output logic [31:0]         EX_MEM_RdData,
  output logic [EX_MEM_W-1:0] EX_MEM
);

  logic [EX_MEM_W-1:0] r_ex_mem;

  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic        w_sign;
  logic [5:0]  w_fun;
  logic        w_src1;
  logic        w_src2;
  logic        w_mem_wr;
  logic        w_mem_rd;
  logic        w_reg_wr;
  logic [1:0]  w_mtr;
  logic [31:0] w_lu_data;
  logic        w_lu_op;
  logic [31:0] w_pc4;
  logic [4:0]  w_shamt;
  logic [31:0] w_imm;
  logic        w_branch;
  logic [1:0]  w_reg_dst;

  assign w_rs_data = ID_EX[ID_RSDATA_MSB:ID_RSDATA_LSB];
  assign w_rt_data = ID_EX[ID_RTDATA_MSB:ID_RTDATA_LSB];
  assign w_rs      = ID_EX[ID_RS_MSB:ID_RS_LSB];
  assign w_rt      = ID_EX[ID_RT_MSB:ID_RT_LSB];
  assign w_rd      = ID_EX[ID_RD_MSB:ID_RD_LSB];
  assign w_sign    = ID_EX[ID_SIGN];
  assign w_fun     = ID_EX[ID_FUN_MSB:ID_FUN_LSB];
  assign w_src2    = ID_EX[ID_SRC2];
  assign w_src1    = ID_EX[ID_SRC1];
  assign w_mem_wr  = ID_EX[ID_MEMWR];
  assign w_mem_rd  = ID_EX[ID_MEMRD];
  assign w_reg_wr  = ID_EX[ID_REGWR];
  assign w_mtr     = ID_EX[ID_MTR_MSB:ID_MTR_LSB];
  assign w_lu_data = ID_EX[ID_LUDATA_MSB:ID_LUDATA_LSB];
  assign w_lu_op   = ID_EX[ID_LUOP];
  assign w_pc4     = ID_EX[ID_PC4_MSB:ID_PC4_LSB];
  assign w_shamt   = ID_EX[ID_SHAMT_MSB:ID_SHAMT_LSB];
  assign w_imm     = ID_EX[ID_IMM_MSB:ID_IMM_LSB];
  assign w_branch  = ID_EX[ID_BRANCH];
  assign w_reg_dst = ID_EX[ID_RDST_MSB:ID_RDST_LSB];

  logic [1:0]  w_em_mtr;
  logic [31:0] w_em_alu;
  logic [31:0] w_em_pc4;

  assign w_em_mtr        = r_ex_mem[EM_MTR_MSB:EM_MTR_LSB];
  assign w_em_alu        = r_ex_mem[EM_ALU_MSB:EM_ALU_LSB];
  assign w_em_pc4        = r_ex_mem[EM_PC4_MSB:EM_PC4_LSB];
  assign EX_MEM_Rd       = r_ex_mem[EM_WREG_MSB:EM_WREG_LSB];
  assign EX_MEM_RegWrite = r_ex_mem[EM_REGWR];
  assign EX_MEM_RdData   = (w_em_mtr == MTR_PC) ? w_em_pc4 : w_em_alu;
  assign EX_MEM          = r_ex_mem;

  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

  assign w_fwd_rs = fwd_sel(w_rs, w_rs_data,
                            EX_MEM_RegWrite, EX_MEM_Rd, EX_MEM_RdData,
                            MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_RdData);
  assign w_fwd_rt = fwd_sel(w_rt, w_rt_data,
                            EX_MEM_RegWrite, EX_MEM_Rd, EX_MEM_RdData,
                            MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_RdData);

  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_z;
  logic [31:0] w_result;

  assign w_alu_a = w_src1 ? {27'b0, w_shamt} : w_fwd_rs;
  assign w_alu_b = w_src2 ? w_imm : w_fwd_rt;

  ex_stage_alu u_alu (
    .i_a    (w_alu_a),
    .i_b    (w_alu_b),
    .i_fun  (w_fun),
    .i_sign (w_sign),
    .o_z    (w_alu_z)
  );

  assign w_result      = w_lu_op ? w_lu_data : w_alu_z;
  assign branch_taken  = w_branch & w_result[0];
  assign branch_target = ID_EX[ID_BADDR_MSB:ID_BADDR_LSB];

  logic [4:0] w_wreg;

  always_comb begin
    w_wreg = w_rd;
    case (w_reg_dst)
      DST_RD:  w_wreg = w_rd;
      DST_RT:  w_wreg = w_rt;
      DST_RA:  w_wreg = RA_REG;
      DST_XP:  w_wreg = XP_REG;
      default: w_wreg = w_rd;
    endcase
  end

  logic [EX_MEM_W-1:0] w_ex_mem_d;

  always_comb begin
    w_ex_mem_d = '0;
    w_ex_mem_d[EM_ALU_MSB:EM_ALU_LSB]     = w_result;
    w_ex_mem_d[EM_STORE_MSB:EM_STORE_LSB] = w_fwd_rt;
    w_ex_mem_d[EM_WREG_MSB:EM_WREG_LSB]   = w_wreg;
    w_ex_mem_d[EM_MEMWR]                  = w_mem_wr;
    w_ex_mem_d[EM_MEMRD]                  = w_mem_rd;
    w_ex_mem_d[EM_REGWR]                  = w_reg_wr;
    w_ex_mem_d[EM_MTR_MSB:EM_MTR_LSB]     = w_mtr;
    w_ex_mem_d[EM_PC4_MSB:EM_PC4_LSB]     = w_pc4;
  end

  // A flush squashes the entering instruction into a nop bundle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ex_mem <= '0;
    else if (EX_Flush)
      r_ex_mem <= '0;
    else
      r_ex_mem <= w_ex_mem_d;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the 230-bit ID_EX bundle produced by the decode stage. Forwards operands from its own EX_MEM register and from the MEM_WB inputs, then runs the ALU.
- Resolves conditional branches; raises a branch redirect/flush to IF and ID.
- Registers results into the EX_MEM bundle. Exports the EX_MEM forwarding signals that decode consumes.

Parameters:
- NONE_REG, 5'd0, register index never forwarded and never written.
- RA_REG, 5'd31, write target when RegDst = 2'b10.
- XP_REG, 5'd26, write target when RegDst = 2'b11.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- ID_EX  in  230  decode bundle. Fields: [31:0] RsData; [63:32] RtData; [68:64] Rs; [73:69] Rt; [78:74] Rd; [87] ALUSrc1; [86] ALUSrc2; [85:80] ALUFun; [79] Sign; [119:88] branch_address; [121] MemRead; [120] MemWrite; [124:123] MemToReg; [122] RegWrite; [157] LUOp; [156:125] LUData; [189:158] PC_Plus4; [194:190] Shamt; [226:195] Imm32; [227] Branch; [229:228] RegDst.
- MEM_WB_RegWrite  in  1  writeback-stage write enable
- MEM_WB_Rd  in  5  writeback-stage destination
- MEM_WB_RdData  in  32  writeback-stage data
- EX_Flush  in  1  squash instruction entering EX_MEM (exception)
- branch_taken  out  1  combinational; redirect PC, flush IF_ID and ID_EX
- branch_target  out  32  combinational; equals ID_EX[119:88]
- EX_MEM_Rd  out  5  equals EX_MEM[68:64]
- EX_MEM_RegWrite  out  1  equals EX_MEM[71]
- EX_MEM_RdData  out  32  EX_MEM[105:74] if EX_MEM MemToReg = 2'b10, else EX_MEM[31:0]
- EX_MEM  out  106  registered. Fields: [31:0] ALUOut; [63:32] StoreData; [68:64] WriteReg; [70] MemRead; [69] MemWrite; [73:72] MemToReg; [71] RegWrite; [105:74] PC_Plus4.

Behaviour:
- Reset: EX_MEM = 0 asynchronously. All outputs derived from it are therefore 0. Zero-bundle = nop (no write, no memory access).
- Latency: 1 cycle. ID_EX present in cycle n appears in EX_MEM at edge n+1.
- Forwarding, applied per operand (Rs, Rt):
  - Priority 1: EX_MEM_RegWrite && EX_MEM_Rd != 0 && EX_MEM_Rd == src → EX_MEM_RdData.
  - Priority 2: MEM_WB_RegWrite && MEM_WB_Rd != 0 && MEM_WB_Rd == src → MEM_WB_RdData.
  - Otherwise: the ID_EX data field.
  - Load-use never reaches EX, because decode inserts a bubble. No stall exists in this block.
- ALU operand A: ALUSrc1 ? {27'b0, Shamt} : fwdRs.
- ALU operand B: ALUSrc2 ? Imm32 : fwdRt.
- ALUFun[5:4] = 00, arithmetic:
  - ALUFun[0] = 0: A+B.
  - ALUFun[0] = 1: A−B.
  - 32-bit wrap, no overflow trap.
- ALUFun[5:4] = 01, logic, selected by ALUFun[3:0]:
  - 1000 AND; 1110 OR; 0110 XOR; 0001 NOR; 1010 pass A.
  - Other codes → 0.
- ALUFun[5:4] = 10, shift of B by A[4:0], selected by ALUFun[1:0]:
  - 00 SLL; 01 SRL; 11 SRA; 10 → 0.
- ALUFun[5:4] = 11, compare, result {31'b0, flag}, selected by ALUFun[3:1]:
  - 001 EQ; 000 NE.
  - 010 LT: signed if Sign, else unsigned.
  - 110 LEZ(A); 101 LTZ(A); 111 GTZ(A), all signed.
  - Other codes → 0.
- Result: LUOp ? LUData : ALU result.
- WriteReg by RegDst: 00 Rd; 01 Rt; 10 RA_REG; 11 XP_REG.
- Branch: branch_taken = Branch && result[0]. It is evaluated from the current ID_EX contents and does not depend on EX_Flush. The branch itself still commits to EX_MEM; it has RegWrite = 0.
- StoreData = fwdRt.
- EX_Flush = 1 at an edge: EX_MEM loads 0. It has priority over normal capture.
- A bubble (ID_EX = 0) is decoded as ADD 0+0 with no writes. It yields EX_MEM with RegWrite = MemRead = MemWrite = 0 and branch_taken = 0.
- Reset deasserted mid-stream: the first capture occurs at the first clk edge after release.

Decomposition:
- Shared package holds:
  - ALUFun codes.
  - RegDst and MemToReg encodings.
  - ID_EX and EX_MEM field LSB/MSB localparams.
- One sub-module is natural: alu (A, B, ALUFun, Sign → Z). It is purely combinational and sits inside ex_stage alongside the forwarding muxes and the register.

Test Plan:
- Reset: reset = 1 with ID_EX random → EX_MEM = 0, branch_taken = 0. Release, then ADD with Rs=5, RsData=3, Rt=6, RtData=4, RegDst=00, Rd=7, RegWrite=1 → next edge EX_MEM[31:0] = 7, WriteReg = 7, RegWrite = 1.
- Back-to-back dependency, EX_MEM path: ADD $7 = 3+4, then SUB $8 = $7 − $6 with stale RsData=0 → EX_MEM ALUOut = 3.
- Forwarding priority: EX_MEM and MEM_WB both target $7 (EX_MEM=10, MEM_WB=20) → $7 operand = 10. With EX_MEM_Rd=0 → MEM_WB value 20 is used.
- Branch: BEQ, fwdRs = fwdRt = 0x55, ALUFun = 110011, Branch = 1, branch_address = 0x0040_0100 → branch_taken = 1, target 0x0040_0100. With unequal operands → branch_taken = 0.
- Signed compare: SLT, A=0xFFFF_FFFF, B=1 → Sign=1 gives 1; Sign=0 gives 0.
- Shift and other write targets:
  - SRA: Shamt=4, ALUSrc1=1, B=0x8000_0000 → 0xF800_0000.
  - JAL: RegDst=10, MemToReg=10, PC_Plus4=0x1004 → WriteReg=31, EX_MEM_RdData = 0x1004.
  - EX_Flush=1 → EX_MEM = 0.
